// File: rtl/ctrl_rx_cmd_pkg.sv
// Shared constants for the RX command sequencer: opcodes, FSM state encoding and ALU operand addresses.
package ctrl_rx_cmd_pkg;

  localparam int unsigned OP_W      = 8;
  localparam int unsigned FUN_W     = 4;
  localparam int unsigned ST_W      = 3;

  localparam logic [OP_W-1:0] OP_REG_WR  = 8'hAA;
  localparam logic [OP_W-1:0] OP_REG_RD  = 8'hBB;
  localparam logic [OP_W-1:0] OP_ALU_OP  = 8'hCC;
  localparam logic [OP_W-1:0] OP_ALU_NOP = 8'hDD;

  localparam int unsigned ALU_A_ADDR = 0;
  localparam int unsigned ALU_B_ADDR = 1;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_WR_ADR = 3'd1,
    ST_WR_DAT = 3'd2,
    ST_RD_ADR = 3'd3,
    ST_ALU_A  = 3'd4,
    ST_ALU_B  = 3'd5,
    ST_ALU_FN = 3'd6
  } state_e;

endpackage

// File: rtl/ctrl_rx_cmd_timeout_cnt.sv
// Idle-cycle counter for an open frame; expired_c flags the LIMIT-th consecutive cycle without a clear.
module cmd_timeout_cnt #(
  parameter int unsigned LIMIT = 4096
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  output logic expired_c
);

  localparam int unsigned CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  // Saturate at the expiry value; a clear on the expiry cycle suppresses the flag.
  always_comb begin
    expired_c = !clr && (cnt_q == CNT_W'(LIMIT - 1));
    cnt_d     = cnt_q;
    if (clr)             cnt_d = '0;
    else if (!expired_c) cnt_d = cnt_q + CNT_W'(1);
  end

endmodule

// File: rtl/ctrl_rx_cmd.sv
// Receive-side command sequencer: decodes UART RX byte frames into regfile/ALU/TX controls.
// Optional in-frame idle timeout enabled by defining CMD_TIMEOUT_EN.
module ctrl_rx_cmd
  import ctrl_rx_cmd_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [WIDTH-1:0]  RX_P_DATA,
  input  logic              RX_D_VLD,
  output logic [ADDR_W-1:0] Address,
  output logic              WrEn,
  output logic [WIDTH-1:0]  WrData,
  output logic              RdEn,
  output logic [FUN_W-1:0]  ALU_FUN,
  output logic              ALU_EN,
  output logic              CLK_GATE_EN,
  output logic              enable_alu,
  output logic              enable_reg,
  output logic              CMD_ERR
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WIDTH-1:0]    wr_data_q, wr_data_d;
  logic [FUN_W-1:0]    alu_fun_q, alu_fun_d;
  logic                wr_en_q, wr_en_d;
  logic                rd_en_q, rd_en_d;
  logic                alu_en_q, alu_en_d;
  logic                gate_q, gate_d;
  logic                en_alu_q, en_alu_d;
  logic                en_reg_q, en_reg_d;
  logic                cmd_err_q, cmd_err_d;
  logic                timeout_c;

`ifdef CMD_TIMEOUT_EN
  cmd_timeout_cnt #(.LIMIT(TIMEOUT_CYC)) u_timeout (
    .CLK       (CLK),
    .RST       (RST),
    .clr       (RX_D_VLD || (state_q == ST_IDLE)),
    .expired_c (timeout_c)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |TIMEOUT_CYC;
  assign timeout_c          = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wr_data_q <= '0;
      alu_fun_q <= '0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      alu_en_q  <= 1'b0;
      gate_q    <= 1'b0;
      en_alu_q  <= 1'b0;
      en_reg_q  <= 1'b0;
      cmd_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wr_data_q <= wr_data_d;
      alu_fun_q <= alu_fun_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      alu_en_q  <= alu_en_d;
      gate_q    <= gate_d;
      en_alu_q  <= en_alu_d;
      en_reg_q  <= en_reg_d;
      cmd_err_q <= cmd_err_d;
    end
  end

  // Next state and outputs; the clock gate drops the cycle after ALU_EN unless a new ALU frame opens.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wr_data_d = wr_data_q;
    alu_fun_d = alu_fun_q;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    alu_en_d  = 1'b0;
    en_alu_d  = 1'b0;
    en_reg_d  = 1'b0;
    cmd_err_d = 1'b0;
    gate_d    = gate_q && !alu_en_q;
    if (RX_D_VLD) begin
      unique case (state_q)
        ST_IDLE: begin
          if (RX_P_DATA == WIDTH'(OP_REG_WR))       state_d = ST_WR_ADR;
          else if (RX_P_DATA == WIDTH'(OP_REG_RD))  state_d = ST_RD_ADR;
          else if (RX_P_DATA == WIDTH'(OP_ALU_OP)) begin
            state_d = ST_ALU_A;
            gate_d  = 1'b1;
          end else if (RX_P_DATA == WIDTH'(OP_ALU_NOP)) begin
            state_d = ST_ALU_FN;
            gate_d  = 1'b1;
          end else begin
            cmd_err_d = 1'b1;
          end
        end
        ST_WR_ADR: begin
          addr_d  = RX_P_DATA[ADDR_W-1:0];
          state_d = ST_WR_DAT;
        end
        ST_WR_DAT: begin
          wr_en_d   = 1'b1;
          wr_data_d = RX_P_DATA;
          state_d   = ST_IDLE;
        end
        ST_RD_ADR: begin
          addr_d   = RX_P_DATA[ADDR_W-1:0];
          rd_en_d  = 1'b1;
          en_reg_d = 1'b1;
          state_d  = ST_IDLE;
        end
        ST_ALU_A: begin
          addr_d    = ADDR_W'(ALU_A_ADDR);
          wr_data_d = RX_P_DATA;
          wr_en_d   = 1'b1;
          state_d   = ST_ALU_B;
        end
        ST_ALU_B: begin
          addr_d    = ADDR_W'(ALU_B_ADDR);
          wr_data_d = RX_P_DATA;
          wr_en_d   = 1'b1;
          state_d   = ST_ALU_FN;
        end
        ST_ALU_FN: begin
          alu_fun_d = RX_P_DATA[FUN_W-1:0];
          alu_en_d  = 1'b1;
          en_alu_d  = 1'b1;
          state_d   = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (timeout_c && (state_q != ST_IDLE)) begin
      state_d   = ST_IDLE;
      cmd_err_d = 1'b1;
      gate_d    = 1'b0;
    end
  end

  assign Address     = addr_q;
  assign WrEn        = wr_en_q;
  assign WrData      = wr_data_q;
  assign RdEn        = rd_en_q;
  assign ALU_FUN     = alu_fun_q;
  assign ALU_EN      = alu_en_q;
  assign CLK_GATE_EN = gate_q;
  assign enable_alu  = en_alu_q;
  assign enable_reg  = en_reg_q;
  assign CMD_ERR     = cmd_err_q;

endmodule

// File: tb/tb_ctrl_rx_cmd.sv
// Scoreboard bench for ctrl_rx_cmd: a frame-level model queues expected strobe events, a monitor checks them.
module tb_ctrl_rx_cmd;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] RX_P_DATA;
  logic       RX_D_VLD;
  logic [3:0] Address;
  logic       WrEn;
  logic [7:0] WrData;
  logic       RdEn;
  logic [3:0] ALU_FUN;
  logic       ALU_EN;
  logic       CLK_GATE_EN;
  logic       enable_alu;
  logic       enable_reg;
  logic       CMD_ERR;

  ctrl_rx_cmd dut (
    .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .Address(Address), .WrEn(WrEn), .WrData(WrData), .RdEn(RdEn),
    .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN), .CLK_GATE_EN(CLK_GATE_EN),
    .enable_alu(enable_alu), .enable_reg(enable_reg), .CMD_ERR(CMD_ERR)
  );

  always #5 CLK = ~CLK;

  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] at;
    logic wr, rd, alu, en_alu, en_reg, err, gate;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [3:0] fun;
  } ev_t;

  ev_t        exp_q[$];
  int         n_chk  = 0;
  int         n_fail = 0;

  // Frame-level reference: bytes of the open frame plus the held register outputs.
  logic [7:0] frame[$];
  logic [3:0] m_addr;
  logic [7:0] m_wdata;
  logic [3:0] m_fun;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h need %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push_ev(input logic wr, input logic rd, input logic alu, input logic err,
                         input logic gate, input int unsigned at);
    ev_t e;
    e.at = at; e.wr = wr; e.rd = rd; e.alu = alu; e.en_alu = alu; e.en_reg = rd;
    e.err = err; e.gate = gate; e.addr = m_addr; e.wdata = m_wdata; e.fun = m_fun;
    exp_q.push_back(e);
  endtask

  task automatic model_byte(input logic [7:0] b, input int unsigned at);
    logic [7:0] op;
    int         idx;
    bit         done;
    if (frame.size() == 0) begin
      if (b inside {8'hAA, 8'hBB, 8'hCC, 8'hDD}) frame.push_back(b);
      else push_ev(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, at);
    end else begin
      op   = frame[0];
      idx  = frame.size();
      done = 1'b0;
      frame.push_back(b);
      case (op)
        8'hAA: if (idx == 1) m_addr = b[3:0];
               else begin m_wdata = b; push_ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, at); done = 1'b1; end
        8'hBB: begin m_addr = b[3:0]; push_ev(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, at); done = 1'b1; end
        8'hCC: if (idx < 3) begin
                 m_addr = 4'(idx - 1); m_wdata = b; push_ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, at);
               end else begin
                 m_fun = b[3:0]; push_ev(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, at); done = 1'b1;
               end
        default: begin m_fun = b[3:0]; push_ev(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, at); done = 1'b1; end
      endcase
      if (done) frame.delete();
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d);
    @(negedge CLK);
    RX_D_VLD  = v;
    RX_P_DATA = d;
    if (v) model_byte(d, cyc + 1);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 8'($urandom));
  endtask

  task automatic pulse_reset();
    @(negedge CLK);
    RST = 1'b0; RX_D_VLD = 1'b0;
    frame.delete(); m_addr = '0; m_wdata = '0; m_fun = '0;
    @(negedge CLK);
    chk("reset_outs", 32'({Address, WrEn, WrData, RdEn, ALU_FUN, ALU_EN, CLK_GATE_EN,
                          enable_alu, enable_reg, CMD_ERR}), 32'd0);
    RST = 1'b1;
  endtask

  function automatic int frame_len(input logic [7:0] op);
    case (op)
      8'hAA:   return 3;
      8'hBB:   return 2;
      8'hCC:   return 4;
      8'hDD:   return 2;
      default: return 1;
    endcase
  endfunction

  // Monitor: every strobe cycle must match the oldest expected event; overdue events are misses.
  always @(negedge CLK) begin : monitor
    ev_t a, e;
    if (RST) begin
      while (exp_q.size() != 0 && exp_q[0].at < cyc) begin
        e = exp_q.pop_front();
        n_chk++; n_fail++;
        $display("FAIL missed_event: got none need event due cyc %0d (now %0d)", e.at, cyc);
      end
      if (WrEn || RdEn || ALU_EN || enable_alu || enable_reg || CMD_ERR) begin
        a.at = cyc; a.wr = WrEn; a.rd = RdEn; a.alu = ALU_EN; a.en_alu = enable_alu;
        a.en_reg = enable_reg; a.err = CMD_ERR; a.gate = CLK_GATE_EN;
        a.addr = Address; a.wdata = WrData; a.fun = ALU_FUN;
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_strobe: got %h need no strobe (cyc %0d)", a, cyc);
        end else begin
          e = exp_q.pop_front();
          if (a !== e) begin
            n_fail++;
            $display("FAIL event: got cyc=%0d wr=%b rd=%b alu=%b ea=%b er=%b err=%b gate=%b addr=%h wd=%h fun=%h need cyc=%0d wr=%b rd=%b alu=%b ea=%b er=%b err=%b gate=%b addr=%h wd=%h fun=%h",
                     a.at, a.wr, a.rd, a.alu, a.en_alu, a.en_reg, a.err, a.gate, a.addr, a.wdata, a.fun,
                     e.at, e.wr, e.rd, e.alu, e.en_alu, e.en_reg, e.err, e.gate, e.addr, e.wdata, e.fun);
          end
        end
      end
    end
  end

  initial begin : stim
    logic [7:0] op;
    int unsigned tmo_at;
    RST = 1'b0; RX_D_VLD = 1'b0; RX_P_DATA = '0;
    m_addr = '0; m_wdata = '0; m_fun = '0;
    repeat (2) @(negedge CLK);
    chk("reset_outs", 32'({Address, WrEn, WrData, RdEn, ALU_FUN, ALU_EN, CLK_GATE_EN,
                          enable_alu, enable_reg, CMD_ERR}), 32'd0);
    RST = 1'b1;
    idle(2);

    // Register write frame.
    drive(1, 8'hAA); idle(1); drive(1, 8'h05); drive(1, 8'h3C); idle(3);
    chk("wr_addr_hold", 32'(Address), 32'h5);
    chk("wr_data_hold", 32'(WrData), 32'h3C);

    // Register read frame.
    drive(1, 8'hBB); drive(1, 8'h07); idle(2);
    chk("rd_addr_hold", 32'(Address), 32'h7);

    // ALU frame with operands; clock gate must stay up across gaps.
    drive(1, 8'hCC); drive(0, 8'h00);
    chk("gate_after_cc", 32'(CLK_GATE_EN), 32'd1);
    drive(1, 8'h12); idle(2);
    chk("gate_mid_frame", 32'(CLK_GATE_EN), 32'd1);
    drive(1, 8'h34); idle(1); drive(1, 8'h02); idle(3);
    chk("gate_dropped", 32'(CLK_GATE_EN), 32'd0);
    chk("alu_fun_hold", 32'(ALU_FUN), 32'h2);

    // Back-to-back ALU-no-operand frame then a bad opcode.
    drive(1, 8'hDD); drive(1, 8'h0A); drive(1, 8'h55); idle(2);
    chk("alu_fun_a", 32'(ALU_FUN), 32'hA);

    // Reset mid-frame discards it; the next byte is decoded as an opcode.
    drive(1, 8'hAA); drive(1, 8'h03); pulse_reset();
    drive(1, 8'h99); idle(3);
    chk("addr_after_rst", 32'(Address), 32'h0);

`ifdef CMD_TIMEOUT_EN
    drive(1, 8'hCC); drive(1, 8'h11);
    tmo_at = cyc + 1 + 4096;
    frame.delete();
    push_ev(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, tmo_at);
    idle(4100);
    chk("gate_after_tmo", 32'(CLK_GATE_EN), 32'd0);
    drive(1, 8'hDD); drive(1, 8'h01); idle(2);
    chk("fun_after_tmo", 32'(ALU_FUN), 32'h1);
`else
    tmo_at = 0;
`endif

    // Random frames with random payload (opcode values included) and short gaps.
    for (int f = 0; f < 80; f++) begin
      case ($urandom_range(0, 4))
        0: op = 8'hAA;
        1: op = 8'hBB;
        2: op = 8'hCC;
        3: op = 8'hDD;
        default: op = 8'($urandom);
      endcase
      drive(1, op);
      for (int i = 1; i < frame_len(op); i++) begin
        idle($urandom_range(0, 2));
        drive(1, ($urandom_range(0, 3) == 0) ? 8'hAA + 8'($urandom_range(0, 3)) * 8'h11
                                              : 8'($urandom));
      end
      idle($urandom_range(0, 2));
    end
    idle(5);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
